stopwatch_core: RTL and testbench

Parametrised stopwatch engine: N-digit BCD time counter with internal tick divider, start/stop, lap (split) hold and clear. It replaces the fixed 4-digit ticker / BCD-counter / holder / latch arrangement with one block. Output is a packed BCD bus for the per-digit 7-segment decoders. Button inputs are synchronised, active-high levels; the block does its own rising-edge detection.

---
 rtl/stopwatch_pkg.sv | 34 +++
 rtl/stopwatch_tick_gen.sv | 29 ++
 rtl/stopwatch_core.sv | 134 +++++++++++++
 tb/tb_stopwatch_core.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch engine.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUNNING,
    STOPPED
  } state_e;

  typedef struct packed {
    logic             carry;
    logic [BCD_W-1:0] digit;
  } bcd_inc_t;

  // Advance one BCD digit by carry_in; carry out is set when a 9 rolls to 0.
  function automatic bcd_inc_t bcd_inc_digit(input logic [BCD_W-1:0] digit,
                                             input logic             carry_in);
    bcd_inc_t res;
    res.carry = 1'b0;
    res.digit = digit;
    if (carry_in) begin
      if (digit == BCD_W'(9)) begin
        res.digit = '0;
        res.carry = 1'b1;
      end else begin
        res.digit = digit + BCD_W'(1);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Tick divider: counts 0..TICK_DIV-1 while enabled, pulses tick on the terminal count.
module stopwatch_tick_gen #(
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned DivW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  logic [DivW-1:0] div_q;

  // Divider holds its value when disabled so a resumed run finishes the partial tick.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      div_q <= '0;
    end else if (enable) begin
      div_q <= (div_q == DivMax) ? '0 : div_q + DivW'(1);
    end
  end

  // Combinational so the count advances on the same edge the divider wraps.
  assign tick = enable && !clear && (div_q == DivMax);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch engine: button edge detect, run/stop FSM, BCD counter, lap split and clear.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 50000,
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned WRAP       = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_stop,
  input  logic                        lap,
  input  logic                        clear,
  output logic [BCD_W*NUM_DIGITS-1:0] bcd_out,
  output logic                        running,
  output logic                        lap_active,
  output logic                        overflow
);

  localparam int unsigned CntW = BCD_W * NUM_DIGITS;

  logic ss_q, lap_q, clr_q;
  logic ss_ev, lap_ev, clr_ev;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d, count_inc;
  logic [CntW-1:0] split_q, split_d;
  logic            lap_d, ovf_d;
  logic            tick;
  logic [NUM_DIGITS:0] carry;

  // Previous button levels for rising-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      ss_q  <= 1'b0;
      lap_q <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      ss_q  <= start_stop;
      lap_q <= lap;
      clr_q <= clear;
    end
  end

  assign ss_ev  = start_stop & ~ss_q;
  assign lap_ev = lap & ~lap_q;
  assign clr_ev = clear & ~clr_q;

  stopwatch_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clock  (clock),
    .reset  (reset),
    .enable (state_q == RUNNING),
    .clear  (clr_ev | (ss_ev & (state_q == IDLE))),
    .tick   (tick)
  );

  // Cascaded BCD increment; carry[NUM_DIGITS] flags an all-9s rollover.
  assign carry[0] = tick;
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    bcd_inc_t inc;
    assign inc = bcd_inc_digit(count_q[i*BCD_W +: BCD_W], carry[i]);
    assign count_inc[i*BCD_W +: BCD_W] = inc.digit;
    assign carry[i+1] = inc.carry;
  end

  // Next-state: clear dominates; lap is judged on the pre-edge state and count.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    split_d = split_q;
    lap_d   = lap_active;
    ovf_d   = overflow;
    if (clr_ev) begin
      state_d = IDLE;
      count_d = '0;
      split_d = '0;
      lap_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (ss_ev && !overflow) begin
        unique case (state_q)
          IDLE:    state_d = RUNNING;
          RUNNING: state_d = STOPPED;
          STOPPED: state_d = RUNNING;
          default: state_d = IDLE;
        endcase
      end
      if (lap_ev) begin
        if (state_q == RUNNING) begin
          if (!lap_active) begin
            split_d = count_q;
            lap_d   = 1'b1;
          end else begin
            lap_d = 1'b0;
          end
        end else if (state_q == STOPPED) begin
          lap_d = 1'b0;
        end
      end
      if (tick) begin
        if (carry[NUM_DIGITS] && (WRAP == 0)) begin
          ovf_d   = 1'b1;
          state_d = STOPPED;
        end else begin
          count_d = count_inc;
        end
      end
    end
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      split_q    <= '0;
      lap_active <= 1'b0;
      overflow   <= 1'b0;
      bcd_out    <= '0;
      running    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      split_q    <= split_d;
      lap_active <= lap_d;
      overflow   <= ovf_d;
      bcd_out    <= lap_d ? split_d : count_d;
      running    <= (state_d == RUNNING);
    end
  end

endmodule

// File: tb/tb_stopwatch_core.sv
module tb_stopwatch_core;

  localparam int TD   = 4;
  localparam int MAXV = 99;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STOP = 2;

  logic       clock = 1'b0;
  logic       reset, start_stop, lap, clear;
  logic [7:0] bcd_w, bcd_s;
  logic       run_w, run_s, lap_w, lap_s, ovf_w, ovf_s;

  always #5 clock = ~clock;

  stopwatch_core #(.TICK_DIV(TD), .NUM_DIGITS(2), .WRAP(1)) dut_w (
    .clock(clock), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .bcd_out(bcd_w), .running(run_w), .lap_active(lap_w), .overflow(ovf_w)
  );

  stopwatch_core #(.TICK_DIV(TD), .NUM_DIGITS(2), .WRAP(0)) dut_s (
    .clock(clock), .reset(reset), .start_stop(start_stop), .lap(lap), .clear(clear),
    .bcd_out(bcd_s), .running(run_s), .lap_active(lap_s), .overflow(ovf_s)
  );

  typedef struct {
    int st;
    int div;
    int cnt;
    int split;
    bit lapact;
    bit ovf;
    bit ssp;
    bit lpp;
    bit clp;
  } mdl_t;

  typedef struct {
    int unsigned due;
    logic [7:0]  bcd_w, bcd_s;
    logic        run_w, run_s, lap_w, lap_s, ovf_w, ovf_s;
  } exp_t;

  mdl_t        m_w = '{default: 0};
  mdl_t        m_s = '{default: 0};
  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, want, cyc);
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r = 8'(((v / 10) << 4) | (v % 10));
    return r;
  endfunction

  // Behavioural model: integer count/divider, edge events from previous levels.
  function automatic mdl_t model_next(input mdl_t m, input bit r, input bit ss, input bit lp,
                                      input bit cl, input bit wrap);
    mdl_t n;
    bit   ss_ev, lp_ev, cl_ev, tick;
    n = m;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    ss_ev = ss && !m.ssp;
    lp_ev = lp && !m.lpp;
    cl_ev = cl && !m.clp;
    n.ssp = ss;
    n.lpp = lp;
    n.clp = cl;
    if (cl_ev) begin
      n.st = S_IDLE; n.div = 0; n.cnt = 0; n.split = 0; n.lapact = 0; n.ovf = 0;
      return n;
    end
    tick = (m.st == S_RUN) && (m.div == TD - 1);
    if (m.st == S_RUN) n.div = (m.div + 1) % TD;
    if (ss_ev && !m.ovf) begin
      if (m.st == S_IDLE) begin
        n.st  = S_RUN;
        n.div = 0;
      end else if (m.st == S_RUN) n.st = S_STOP;
      else n.st = S_RUN;
    end
    if (lp_ev) begin
      if (m.st == S_RUN) begin
        if (!m.lapact) begin
          n.split  = m.cnt;
          n.lapact = 1;
        end else n.lapact = 0;
      end else if (m.st == S_STOP) n.lapact = 0;
    end
    if (tick) begin
      if (m.cnt == MAXV) begin
        if (wrap) n.cnt = 0;
        else begin
          n.ovf = 1;
          n.st  = S_STOP;
        end
      end else n.cnt = m.cnt + 1;
    end
    return n;
  endfunction

  // Drive one cycle of inputs, push the expectation for the coming edge, wait to the next negedge.
  task automatic step(input bit r, input bit ss, input bit lp, input bit cl);
    exp_t e;
    reset = r; start_stop = ss; lap = lp; clear = cl;
    m_w = model_next(m_w, r, ss, lp, cl, 1'b1);
    m_s = model_next(m_s, r, ss, lp, cl, 1'b0);
    e.due   = cyc + 1;
    e.bcd_w = to_bcd(m_w.lapact ? m_w.split : m_w.cnt);
    e.bcd_s = to_bcd(m_s.lapact ? m_s.split : m_s.cnt);
    e.run_w = (m_w.st == S_RUN);
    e.run_s = (m_s.st == S_RUN);
    e.lap_w = m_w.lapact;
    e.lap_s = m_s.lapact;
    e.ovf_w = m_w.ovf;
    e.ovf_s = m_s.ovf;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic restart();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compare every due expectation against both DUTs.
  always @(negedge clock) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      chk("w_bcd", 32'(bcd_w), 32'(e.bcd_w));
      chk("w_running", 32'(run_w), 32'(e.run_w));
      chk("w_lap_active", 32'(lap_w), 32'(e.lap_w));
      chk("w_overflow", 32'(ovf_w), 32'(e.ovf_w));
      chk("s_bcd", 32'(bcd_s), 32'(e.bcd_s));
      chk("s_running", 32'(run_s), 32'(e.run_s));
      chk("s_lap_active", 32'(lap_s), 32'(e.lap_s));
      chk("s_overflow", 32'(ovf_s), 32'(e.ovf_s));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rs, rl, rc, rr;
    reset = 1'b1; start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
    @(negedge clock);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("reset_bcd", 32'(bcd_w), 32'h0);
    chk("reset_running", 32'(run_w), 32'h0);
    idle(2);

    // First increment four edges after start; 8'h10 at edge 40.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    chk("start_no_inc_yet", 32'(bcd_w), 32'h00);
    idle(1);
    chk("start_first_inc", 32'(bcd_w), 32'h01);
    idle(36);
    chk("run40_bcd", 32'(bcd_w), 32'h10);
    chk("run40_running", 32'(run_w), 32'h1);

    // Stop with the divider part-way; resume finishes the partial tick.
    restart();
    idle(20);
    chk("stop_pre_count", 32'(bcd_w), 32'h05);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("stopped_hold_bcd", 32'(bcd_w), 32'h05);
    chk("stopped_running", 32'(run_w), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    chk("resume_no_inc", 32'(bcd_w), 32'h05);
    idle(1);
    chk("resume_inc", 32'(bcd_w), 32'h06);

    // Wrap versus saturate at all-9s.
    restart();
    idle(392);
    chk("pre_wrap_98", 32'(bcd_w), 32'h98);
    idle(4);
    chk("wrap_99", 32'(bcd_w), 32'h99);
    chk("sat_99", 32'(bcd_s), 32'h99);
    idle(4);
    chk("wrap_00", 32'(bcd_w), 32'h00);
    chk("wrap_no_ovf", 32'(ovf_w), 32'h0);
    chk("sat_hold", 32'(bcd_s), 32'h99);
    chk("sat_ovf", 32'(ovf_s), 32'h1);
    chk("sat_stopped", 32'(run_s), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    chk("sat_start_ignored", 32'(run_s), 32'h0);
    chk("sat_still_99", 32'(bcd_s), 32'h99);

    // Lap freezes the display; second press shows the live count.
    restart();
    idle(48);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("lap_frozen", 32'(bcd_w), 32'h12);
    chk("lap_active_set", 32'(lap_w), 32'h1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap_release", 32'(bcd_w), 32'h17);
    chk("lap_active_clr", 32'(lap_w), 32'h0);

    // Lap on the same edge as a tick captures the pre-increment value.
    restart();
    idle(15);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap_on_tick", 32'(bcd_w), 32'h03);

    // Clear dominates simultaneous start_stop and lap; held button gives one event.
    restart();
    idle(168);
    chk("pre_clear_42", 32'(bcd_w), 32'h42);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    chk("clear_bcd", 32'(bcd_w), 32'h0);
    chk("clear_running", 32'(run_w), 32'h0);
    chk("clear_lap", 32'(lap_w), 32'h0);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("held_after_clear", 32'(run_w), 32'h0);
    idle(1);
    repeat (10) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("held_one_event", 32'(run_w), 32'h1);
    idle(1);

    // Randomised button levels with occasional reset.
    rs = 0; rl = 0; rc = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) rs = !rs;
      if ($urandom_range(0, 6) == 0) rl = !rl;
      if ($urandom_range(0, 24) == 0) rc = !rc;
      rr = ($urandom_range(0, 149) == 0);
      step(rr, rs, rl, rc);
    end

    idle(2);
    @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
